// File: rtl/regbank_pkg.sv
// regbank_pkg: shared constants and types for the 16x32 register bank and
// its clients.
//   DATA_W / ADDR_W / NREG : bank geometry
//   reg_addr_t / reg_data_t : address and data types
//   opnd_t                  : captured operand bundle held by operand_fetch
package regbank_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NREG   = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef struct packed {
    reg_data_t a;
    reg_data_t b;
    reg_addr_t dest;
    logic      wen;
  } opnd_t;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: one busy bit per register, marking a destination whose
// write is still in flight.
//   clk, reset          : clock, synchronous active-high reset (clears all)
//   set_en / set_idx    : mark a register busy (issue of a writing instr)
//   clr_en / clr_idx    : mark a register free (writeback)
//   rd_a / rd_b / rd_d  : lookup indices
//   busy_a/busy_b/busy_d: busy state of the looked-up registers
// A set and a clear of the same index in one cycle leaves the bit set: the
// clear retires the older write, the set records the newer one.
module reg_scoreboard
  import regbank_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int NR = NREG
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] rd_a,
  input  logic [AW-1:0] rd_b,
  input  logic [AW-1:0] rd_d,
  output logic          busy_a,
  output logic          busy_b,
  output logic          busy_d
);

  logic [NR-1:0] busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (set_en && set_idx == AW'(i))
          busy[i] <= 1'b1;
        else if (clr_en && clr_idx == AW'(i))
          busy[i] <= 1'b0;
      end
    end
  end

  assign busy_a = busy[rd_a];
  assign busy_b = busy[rd_b];
  assign busy_d = busy[rd_d];

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: read-side client of the register bank.
//   clk, reset                : clock, synchronous active-high reset
//   req_*                     : decoded instruction in (valid/ready)
//   srcadd1/srcadd2, src1/src2: bank read address out, read data in
//   wb_valid/wb_dest/wb_data  : writeback seen by the bank this cycle
//   op_*                      : one-deep operand stage out (valid/ready)
//   stall_cnt                 : hazard stall cycle counter, present only
//                               when OPFETCH_STALL_STATS_EN is defined
// Pending writes are tracked in reg_scoreboard; a request stalls while a
// source or its destination is busy, unless this cycle's writeback
// retires that register, in which case source data is forwarded from wb_data.
module operand_fetch
  import regbank_pkg::*;
#(
  parameter int DATA_W = regbank_pkg::DATA_W,
  parameter int ADDR_W = regbank_pkg::ADDR_W,
  parameter int NREG   = regbank_pkg::NREG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_srca,
  input  logic [ADDR_W-1:0] req_srcb,
  input  logic [ADDR_W-1:0] req_dest,
  input  logic              req_wen,
  output logic [ADDR_W-1:0] srcadd1,
  output logic [ADDR_W-1:0] srcadd2,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] op_dest,
  output logic              op_wen
`ifdef OPFETCH_STALL_STATS_EN
  ,output logic [15:0]      stall_cnt
`endif
);

  logic busy_a, busy_b, busy_d;
  logic fwd_a, fwd_b, fwd_d;
  logic hazard, accept;

  assign srcadd1 = req_srca;
  assign srcadd2 = req_srcb;

  reg_scoreboard #(.AW(ADDR_W), .NR(NREG)) u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (accept && req_wen),
    .set_idx (req_dest),
    .clr_en  (wb_valid),
    .clr_idx (wb_dest),
    .rd_a    (req_srca),
    .rd_b    (req_srcb),
    .rd_d    (req_dest),
    .busy_a  (busy_a),
    .busy_b  (busy_b),
    .busy_d  (busy_d)
  );

  assign fwd_a = wb_valid && (wb_dest == req_srca);
  assign fwd_b = wb_valid && (wb_dest == req_srcb);
  assign fwd_d = wb_valid && (wb_dest == req_dest);

  // A busy register whose writeback lands this cycle is no longer a hazard:
  // sources take wb_data, and a WAW dest simply re-arms the busy bit.
  assign hazard = (busy_a && !fwd_a) || (busy_b && !fwd_b) ||
                  (req_wen && busy_d && !fwd_d);

  // Deliberately independent of req_valid so upstream may wait on it.
  assign req_ready = (!op_valid || op_ready) && !hazard;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_dest  <= '0;
      op_wen   <= 1'b0;
    end else if (accept) begin
      op_valid <= 1'b1;
      op_a     <= fwd_a ? wb_data : src1;
      op_b     <= fwd_b ? wb_data : src2;
      op_dest  <= req_dest;
      op_wen   <= req_wen;
    end else if (op_ready) begin
      // Drain: data outputs keep their last value.
      op_valid <= 1'b0;
    end
  end

`ifdef OPFETCH_STALL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (req_valid && hazard && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read-side client of the 16x32 register bank.
- Accepts decoded instruction requests (srcA, srcB, dest) and drives the bank read addresses.
- Captures operands into a one-deep output stage with valid/ready handshake.
- Tracks pending destination writes in a busy-bit scoreboard: stalls on RAW/WAW hazards; forwards same-cycle writeback data.

Parameters:
- DATA_W, 32, operand/writeback data width
- ADDR_W, 4, register address width
- NREG, 16, number of registers (2**ADDR_W)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_srca  in  ADDR_W  operand A register
- req_srcb  in  ADDR_W  operand B register
- req_dest  in  ADDR_W  destination register
- req_wen  in  1  instruction writes req_dest
- srcadd1  out  ADDR_W  bank read address 1 (combinational = req_srca)
- srcadd2  out  ADDR_W  bank read address 2 (combinational = req_srcb)
- src1  in  DATA_W  bank read data 1 (combinational from bank)
- src2  in  DATA_W  bank read data 2
- wb_valid  in  1  writeback occurring this cycle (same as bank write)
- wb_dest  in  ADDR_W  writeback register
- wb_data  in  DATA_W  writeback data
- op_valid  out  1  operand stage holds valid data
- op_ready  in  1  consumer takes operands
- op_a  out  DATA_W  operand A
- op_b  out  DATA_W  operand B
- op_dest  out  ADDR_W  destination
- op_wen  out  1  destination write flag

Behaviour:
- Reset (sync, active-high):
  - op_valid=0; op_a=op_b=0; op_dest=0; op_wen=0.
  - All busy bits cleared.
  - Reset overrides any simultaneous accept/writeback, including mid-stall.
- Hazard (combinational):
  - fwdA = wb_valid && wb_dest==req_srca; fwdB likewise.
  - hazard = (busy[srca] && !fwdA) || (busy[srcb] && !fwdB) || (req_wen && busy[dest] && !(wb_valid && wb_dest==req_dest)).
- Handshake:
  - req_ready = (!op_valid || op_ready) && !hazard.
  - req_ready never depends on req_valid.
- Accept (req_valid && req_ready):
  - Next edge: op_valid=1, op_dest/op_wen captured.
  - op_a = fwdA ? wb_data : src1; op_b = fwdB ? wb_data : src2.
  - Latency 1 cycle from accept to op_valid.
- Hold: op_valid && !op_ready -> all op_* outputs stable.
- Drain: op_valid && op_ready with no accept -> op_valid=0; data outputs retain last value.
- Back-to-back: op_ready && accept in the same cycle -> new operands replace old, op_valid stays 1. Sustains 1 op/cycle.
- Scoreboard:
  - accept with req_wen sets busy[req_dest].
  - wb_valid clears busy[wb_dest].
  - Same index set and cleared in the same cycle: set wins (new pending write).
- Writeback to a register not marked busy: clears nothing, no error.
- srca==srcb: both operands forwarded or stalled identically.
- No register is hardwired; register 0 is treated like any other.

Optional Feature:
- Macro OPFETCH_STALL_STATS_EN.
- Defined:
  - Extra output stall_cnt (16 bits).
  - Increments each cycle req_valid && hazard; saturates at 0xFFFF; cleared by reset.
- Undefined: port absent, no counter logic; all other behaviour identical.

Decomposition:
- Package regbank_pkg: DATA_W, ADDR_W, NREG constants; typedef reg_addr_t (ADDR_W bits), reg_data_t (DATA_W bits).
- One sub-module: reg_scoreboard.
  - Busy vector with set/clear ports.
  - Three lookup outputs: busy_a, busy_b, busy_d.
- operand_fetch holds handshake, forwarding mux and output register.

Test Plan:
- Reset, then request srca=3, srcb=5, wen=0; bank src1=0x11, src2=0x22 -> next cycle op_valid=1, op_a=0x11, op_b=0x22.
- Issue wen=1, dest=7; then request srca=7 with no writeback -> req_ready=0 until wb_valid, wb_dest=7.
- Same cycle as wb_valid, wb_dest=7, wb_data=0xDEAD -> request accepted, op_a=0xDEAD (forwarded, not src1).
- op_ready=0 for 3 cycles with op_valid=1 -> op_* stable, req_ready=0. Then op_ready=1 with a new request -> operands replaced, op_valid stays 1.
- Accept wen=1, dest=4 while wb_valid, wb_dest=4 in the same cycle -> busy[4]=1 afterward; a later srca=4 request stalls.
- Assert reset while busy[2]=1 and op_valid=1 -> op_valid=0 and a srca=2 request is accepted the cycle after reset deasserts. With OPFETCH_STALL_STATS_EN defined, stall_cnt=0 after reset.
